// File: rtl/npu_pkg.sv
// Shared NPU definitions: MAC issue FSM states, lane-count width and chunk sizing helper.
package npu_pkg;

    localparam int unsigned NUM_MACS_W = 11;
    localparam int unsigned JOB_LEN_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } mac_state_e;

    // Lanes used by the next chunk: min(remaining, max_macs).
    function automatic logic [NUM_MACS_W-1:0] chunk_lanes(
        input logic [JOB_LEN_W-1:0] remaining,
        input int unsigned          max_macs
    );
        if (remaining >= JOB_LEN_W'(max_macs)) begin
            return NUM_MACS_W'(max_macs);
        end
        return NUM_MACS_W'(remaining);
    endfunction

endpackage

// File: rtl/mac_issue.sv
// Splits a dot-product job into MAX_MACS-wide chunks, issues each to an external MAC and accumulates.
// Optional watchdog on the ISSUE wait is compiled in with `define MAC_ISSUE_TIMEOUT_EN.
module mac_issue
    import npu_pkg::*;
#(
    parameter int unsigned MAX_MACS   = 64,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             job_valid,
    output logic                             job_ready,
    input  logic [JOB_LEN_W-1:0]             job_len,
    input  logic                             op_valid,
    output logic                             op_ready,
    input  logic [MAX_MACS*DATA_WIDTH-1:0]   op_data,
    input  logic [MAX_MACS*DATA_WIDTH-1:0]   op_weight,
    output logic                             mac_valid_in,
    output logic [NUM_MACS_W-1:0]            mac_num_macs,
    output logic [MAX_MACS*DATA_WIDTH-1:0]   mac_data,
    output logic [MAX_MACS*DATA_WIDTH-1:0]   mac_weight,
    input  logic [2*DATA_WIDTH-1:0]          mac_out,
    input  logic                             mac_valid_out,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [ACC_WIDTH-1:0]             res_data,
    output logic                             err
);

    localparam int unsigned LANES_W = MAX_MACS * DATA_WIDTH;

    mac_state_e              state_q, state_d;
    logic [JOB_LEN_W-1:0]    remaining_q, remaining_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [NUM_MACS_W-1:0]   num_macs_q, num_macs_d;
    logic [LANES_W-1:0]      data_q, data_d;
    logic [LANES_W-1:0]      weight_q, weight_d;
    logic                    job_ready_q, op_ready_q, mac_valid_in_q, res_valid_q;

`ifdef MAC_ISSUE_TIMEOUT_EN
    localparam int unsigned WD_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        num_macs_d  = num_macs_q;
        data_d      = data_q;
        weight_d    = weight_q;
`ifdef MAC_ISSUE_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    remaining_d = job_len;
                    acc_d       = '0;
                    state_d     = (job_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (op_valid) begin
                    data_d     = op_data;
                    weight_d   = op_weight;
                    num_macs_d = chunk_lanes(remaining_q, MAX_MACS);
                    state_d    = S_ISSUE;
`ifdef MAC_ISSUE_TIMEOUT_EN
                    wd_d       = '0;
`endif
                end
            end
            S_ISSUE: begin
                if (mac_valid_out) begin
                    acc_d       = acc_q + ACC_WIDTH'(mac_out);
                    remaining_d = remaining_q - JOB_LEN_W'(num_macs_q);
                    state_d     = S_GAP;
                end
`ifdef MAC_ISSUE_TIMEOUT_EN
                // Give up after TIMEOUT cycles in ISSUE and report the partial sum
                else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            S_GAP: begin
                state_d = (remaining_q != '0) ? S_FETCH : S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; handshake outputs are registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            remaining_q    <= '0;
            acc_q          <= '0;
            num_macs_q     <= '0;
            data_q         <= '0;
            weight_q       <= '0;
            job_ready_q    <= 1'b1;
            op_ready_q     <= 1'b0;
            mac_valid_in_q <= 1'b0;
            res_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            acc_q          <= acc_d;
            num_macs_q     <= num_macs_d;
            data_q         <= data_d;
            weight_q       <= weight_d;
            job_ready_q    <= (state_d == S_IDLE);
            op_ready_q     <= (state_d == S_FETCH);
            mac_valid_in_q <= (state_d == S_ISSUE);
            res_valid_q    <= (state_d == S_DONE);
        end
    end

`ifdef MAC_ISSUE_TIMEOUT_EN
    // Watchdog counter and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout_c;

    assign unused_timeout_c = (TIMEOUT == 0);
    assign err              = 1'b0;
`endif

    assign job_ready    = job_ready_q;
    assign op_ready     = op_ready_q;
    assign mac_valid_in = mac_valid_in_q;
    assign mac_num_macs = num_macs_q;
    assign mac_data     = data_q;
    assign mac_weight   = weight_q;
    assign res_valid    = res_valid_q;
    assign res_data     = acc_q;

endmodule

// File: tb/tb_mac_issue.sv
// Directed self-checking bench for mac_issue; the bench plays the external MAC.
// Define MAC_ISSUE_TIMEOUT_EN for both files to exercise the watchdog instead of the indefinite wait.
module tb_mac_issue;

    localparam int unsigned MM = 64;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 256;
    localparam int unsigned LW = MM * DW;

    logic             clk;
    logic             rst;
    logic             job_valid;
    logic             job_ready;
    logic [15:0]      job_len;
    logic             op_valid;
    logic             op_ready;
    logic [LW-1:0]    op_data;
    logic [LW-1:0]    op_weight;
    logic             mac_valid_in;
    logic [10:0]      mac_num_macs;
    logic [LW-1:0]    mac_data;
    logic [LW-1:0]    mac_weight;
    logic [2*DW-1:0]  mac_out;
    logic             mac_valid_out;
    logic             res_valid;
    logic             res_ready;
    logic [AW-1:0]    res_data;
    logic             err;

    logic [LW-1:0]    pat_d;
    logic [LW-1:0]    pat_w;

    int total = 0;
    int bad   = 0;

    mac_issue #(
        .MAX_MACS   (MM),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_len       (job_len),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_data       (op_data),
        .op_weight     (op_weight),
        .mac_valid_in  (mac_valid_in),
        .mac_num_macs  (mac_num_macs),
        .mac_data      (mac_data),
        .mac_weight    (mac_weight),
        .mac_out       (mac_out),
        .mac_valid_out (mac_valid_out),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference MAC: sum of lane products over the first n lanes of the fixed pattern
    function automatic logic [15:0] psum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += (i + 1) * (64 - i);
        return 16'(s);
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_job_ready"}, job_ready, 1);
        chk({tag, "_op_ready"}, op_ready, 0);
        chk({tag, "_mac_valid_in"}, mac_valid_in, 0);
        chk({tag, "_num_macs"}, mac_num_macs, 0);
        chk_wide({tag, "_mac_data"}, mac_data, '0);
        chk_wide({tag, "_mac_weight"}, mac_weight, '0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves one cycle after GAP
    task automatic issue_beat(input int n, input int stall);
        chk("fetch_op_ready", op_ready, 1);
        op_data   = pat_d;
        op_weight = pat_w;
        op_valid  = 1'b1;
        @(negedge clk);
        op_valid  = 1'b0;
        op_data   = '0;
        op_weight = '0;
        chk("issue_valid", mac_valid_in, 1);
        chk("issue_num_macs", mac_num_macs, 64'(n));
        chk("issue_op_ready", op_ready, 0);
        chk("issue_job_ready", job_ready, 0);
        chk_wide("issue_data", mac_data, pat_d);
        chk_wide("issue_weight", mac_weight, pat_w);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            chk("stall_valid", mac_valid_in, 1);
            chk("stall_num_macs", mac_num_macs, 64'(n));
            chk_wide("stall_data", mac_data, pat_d);
            chk("stall_res_valid", res_valid, 0);
            chk("stall_err", err, 0);
        end
        mac_out       = psum(n);
        mac_valid_out = 1'b1;
        @(negedge clk);
        mac_valid_out = 1'b0;
        mac_out       = '0;
        chk("gap_valid", mac_valid_in, 0);
        chk("gap_op_ready", op_ready, 0);
        chk("gap_res_valid", res_valid, 0);
        @(negedge clk);
    endtask

    task automatic run_job(input int len, input logic [31:0] exp_res, input int stall);
        int rem;
        int n;
        chk("idle_job_ready", job_ready, 1);
        job_len   = 16'(len);
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        chk("accept_job_ready", job_ready, 0);
        rem = len;
        while (rem > 0) begin
            n = (rem > 64) ? 64 : rem;
            issue_beat(n, stall);
            rem -= n;
        end
        chk("done_res_valid", res_valid, 1);
        chk("done_res_data", res_data, 64'(exp_res));
        chk("done_op_ready", op_ready, 0);
        chk("done_mac_valid", mac_valid_in, 0);
        @(negedge clk);
        chk("hold_res_valid", res_valid, 1);
        chk("hold_res_data", res_data, 64'(exp_res));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("ret_res_valid", res_valid, 0);
        chk("ret_job_ready", job_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            pat_d[i*8 +: 8] = 8'(i + 1);
            pat_w[i*8 +: 8] = 8'(64 - i);
        end
        rst           = 1'b0;
        job_valid     = 1'b0;
        job_len       = '0;
        op_valid      = 1'b0;
        op_data       = '0;
        op_weight     = '0;
        mac_out       = '0;
        mac_valid_out = 1'b0;
        res_ready     = 1'b0;

        #12;
        chk_reset_vals("por");
        @(negedge clk);
        rst = 1'b1;

        // Stray MAC strobe while idle must not disturb anything
        mac_out       = 16'hffff;
        mac_valid_out = 1'b1;
        @(negedge clk);
        mac_valid_out = 1'b0;
        mac_out       = '0;
        chk("stray_job_ready", job_ready, 1);
        chk("stray_mac_valid", mac_valid_in, 0);

        run_job(1, 32'd64, 0);
        run_job(64, 32'd45760, 2);
        run_job(70, 32'd47034, 1);
        run_job(128, 32'd91520, 0);
        run_job(0, 32'd0, 0);

        // Reset while ISSUE is waiting on the MAC
        job_len   = 16'd64;
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        op_data   = pat_d;
        op_weight = pat_w;
        op_valid  = 1'b1;
        @(negedge clk);
        op_valid  = 1'b0;
        chk("pre_rst_issue", mac_valid_in, 1);
        #2 rst = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        run_job(1, 32'd64, 0);

`ifdef MAC_ISSUE_TIMEOUT_EN
        // MAC never answers: error and partial result exactly TO cycles after ISSUE entry
        job_len   = 16'd64;
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        op_data   = pat_d;
        op_weight = pat_w;
        op_valid  = 1'b1;
        @(negedge clk);
        op_valid  = 1'b0;
        chk("to_issue", mac_valid_in, 1);
        repeat (TO - 1) @(negedge clk);
        chk("to_before_res_valid", res_valid, 0);
        chk("to_before_err", err, 0);
        chk("to_before_issue", mac_valid_in, 1);
        @(negedge clk);
        chk("to_res_valid", res_valid, 1);
        chk("to_err", err, 1);
        chk("to_mac_valid", mac_valid_in, 0);
        chk("to_res_data", res_data, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("to_sticky_err", err, 1);
        chk("to_job_ready", job_ready, 1);
        #2 rst = 1'b0;
        #1;
        chk("to_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
`else
        // Without the watchdog ISSUE waits as long as the MAC takes
        run_job(1, 32'd64, 300);
        chk("no_wd_err", err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
